// File: rtl/fft_kar_sched.sv
// Karatsuba twiddle-multiply phase scheduler: locks an f/R/I slot schedule to the
// 1x sync pulse, feeds one shared pipelined multiplier and recombines its products.
module fft_kar_sched #(
  parameter int DW       = 25,
  parameter int TW       = 10,
  parameter int MUL_LAT  = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic                    clk_3x_i,
  input  logic                    rst_n,
  input  logic                    sync_i,
  input  logic                    in_valid_i,
  input  logic signed [DW-1:0]    x_re_i,
  input  logic signed [DW-1:0]    x_im_i,
  input  logic signed [TW-1:0]    w_re_i,
  input  logic signed [TW-1:0]    w_im_i,
  output logic signed [DW:0]      mul_a_o,
  output logic signed [TW:0]      mul_b_o,
  input  logic signed [DW+TW+1:0] dsp_p_i,
  output logic signed [DW-1:0]    z_re_o,
  output logic signed [DW-1:0]    z_im_o,
  output logic                    out_valid_o,
  output logic                    sat_o,
  output logic                    locked_o,
  output logic                    slip_err_o
);

  localparam int PW = DW + TW + 2;
  localparam int CW = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] S_UNLOCK = 2'd0;
  localparam logic [1:0] S_P0     = 2'd1;
  localparam logic [1:0] S_P1     = 2'd2;
  localparam logic [1:0] S_P2     = 2'd3;

  localparam logic signed [DW-1:0] ZMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] ZMIN = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]             r_state, w_state_nxt;
  logic [CW-1:0]          r_lock_cnt;
  logic                   r_slip, r_cur_v, w_cur_v_nxt;
  logic                   w_early_sync, w_missing;
  logic signed [DW-1:0]   r_xr, r_xi, w_xr, w_xi;
  logic signed [TW-1:0]   r_wr, r_wi, w_wr, w_wi;
  logic signed [DW:0]     r_mul_a, w_mul_a;
  logic signed [TW:0]     r_mul_b, w_mul_b;
  logic [MUL_LAT:0]       r_tag_v;
  logic [1:0]             r_tag_s [0:MUL_LAT];
  logic signed [PW-1:0]   r_f, r_r, w_i;
  logic signed [PW-1:0]   w_sh_re, w_sh_im;
  logic signed [DW-1:0]   w_zre, w_zim, r_zre, r_zim;
  logic                   w_sat_re, w_sat_im, r_out_v, r_sat;

  always_comb begin
    w_early_sync = sync_i && ((r_state == S_P0) || (r_state == S_P1));
    w_missing    = !sync_i && (r_state == S_P2);

    w_state_nxt = S_UNLOCK;
    case (r_state)
      S_UNLOCK: w_state_nxt = sync_i ? S_P0 : S_UNLOCK;
      S_P0:     w_state_nxt = sync_i ? S_P0 : S_P1;
      S_P1:     w_state_nxt = sync_i ? S_P0 : S_P2;
      default:  w_state_nxt = S_P0;
    endcase

    // a free-running P0 after a missing sync carries no sample
    w_cur_v_nxt = sync_i ? in_valid_i : ((r_state == S_P2) ? 1'b0 : r_cur_v);

    // slot 0 is issued in the sync cycle itself, so it reads the ports directly
    w_xr = sync_i ? x_re_i : r_xr;
    w_xi = sync_i ? x_im_i : r_xi;
    w_wr = sync_i ? w_re_i : r_wr;
    w_wi = sync_i ? w_im_i : r_wi;

    w_mul_a = '0;
    w_mul_b = '0;
    case (w_state_nxt)
      S_P0: begin
        w_mul_a = {w_xr[DW-1], w_xr} - {w_xi[DW-1], w_xi};
        w_mul_b = {w_wr[TW-1], w_wr};
      end
      S_P1: begin
        w_mul_a = {w_xi[DW-1], w_xi};
        w_mul_b = {w_wr[TW-1], w_wr} - {w_wi[TW-1], w_wi};
      end
      S_P2: begin
        w_mul_a = {w_xr[DW-1], w_xr};
        w_mul_b = {w_wr[TW-1], w_wr} + {w_wi[TW-1], w_wi};
      end
      default: ;
    endcase

    w_i     = dsp_p_i - r_f;
    w_sh_re = r_r >>> (TW - 1);
    w_sh_im = w_i >>> (TW - 1);
    // in range only if everything above the result's sign bit matches it
    w_sat_re = !((w_sh_re[PW-1:DW-1] == '0) || (w_sh_re[PW-1:DW-1] == '1));
    w_sat_im = !((w_sh_im[PW-1:DW-1] == '0) || (w_sh_im[PW-1:DW-1] == '1));
    w_zre = w_sat_re ? (r_r[PW-1] ? ZMIN : ZMAX) : w_sh_re[DW-1:0];
    w_zim = w_sat_im ? (w_i[PW-1] ? ZMIN : ZMAX) : w_sh_im[DW-1:0];
  end

  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      r_state    <= S_UNLOCK;
      r_lock_cnt <= '0;
      r_slip     <= 1'b0;
      r_cur_v    <= 1'b0;
      r_xr       <= '0;
      r_xi       <= '0;
      r_wr       <= '0;
      r_wi       <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_tag_v    <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) r_tag_s[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur_v <= w_cur_v_nxt;
      r_mul_a <= w_mul_a;
      r_mul_b <= w_mul_b;
      r_slip  <= w_early_sync || w_missing;
      if (sync_i) begin
        r_xr <= x_re_i;
        r_xi <= x_im_i;
        r_wr <= w_re_i;
        r_wi <= w_im_i;
      end
      if (w_early_sync || w_missing)
        r_lock_cnt <= '0;
      else if (sync_i && (r_state == S_P2) && (r_lock_cnt != CW'(LOCK_CNT)))
        r_lock_cnt <= r_lock_cnt + CW'(1);
      r_tag_v[0] <= w_cur_v_nxt && (w_state_nxt != S_UNLOCK);
      r_tag_s[0] <= w_state_nxt;
      // the slot interrupted by an early sync is killed as it leaves the issue stage
      r_tag_v[1] <= r_tag_v[0] && !w_early_sync;
      r_tag_s[1] <= r_tag_s[0];
      for (int unsigned k = 2; k <= MUL_LAT; k++) begin
        r_tag_v[k] <= r_tag_v[k-1];
        r_tag_s[k] <= r_tag_s[k-1];
      end
    end
  end

  always_ff @(posedge clk_3x_i) begin
    if (!rst_n) begin
      r_f     <= '0;
      r_r     <= '0;
      r_zre   <= '0;
      r_zim   <= '0;
      r_out_v <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_out_v <= 1'b0;
      r_sat   <= 1'b0;
      if (r_tag_v[MUL_LAT]) begin
        case (r_tag_s[MUL_LAT])
          S_P0: r_f <= dsp_p_i;
          S_P1: r_r <= dsp_p_i + r_f;
          S_P2: begin
            r_zre   <= w_zre;
            r_zim   <= w_zim;
            r_out_v <= 1'b1;
            r_sat   <= w_sat_re || w_sat_im;
          end
          default: ;
        endcase
      end
    end
  end

  assign mul_a_o     = r_mul_a;
  assign mul_b_o     = r_mul_b;
  assign z_re_o      = r_zre;
  assign z_im_o      = r_zim;
  assign out_valid_o = r_out_v;
  assign sat_o       = r_sat;
  assign locked_o    = (r_lock_cnt == CW'(LOCK_CNT));
  assign slip_err_o  = r_slip;

endmodule

// File: tb/tb_fft_kar_sched.sv
// Directed bench for fft_kar_sched with a behavioural 2-stage multiplier and
// hand-computed result table; multi-cycle lock/slip/reset scenarios are scripted.
module tb_fft_kar_sched;
  localparam int DW = 25;
  localparam int TW = 10;
  localparam int ML = 2;
  localparam int LC = 4;

  localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [TW-1:0] WMIN = {1'b1, {(TW-1){1'b0}}};

  typedef struct {
    logic signed [DW-1:0] xr, xi;
    logic signed [TW-1:0] wr, wi;
    logic                 vld;
    logic signed [DW-1:0] ezr, ezi;
    logic                 esat;
  } vec_t;

  typedef struct {
    int                   cyc;
    logic signed [DW-1:0] zr, zi;
    logic                 sat;
  } ev_t;

  logic clk_3x_i = 1'b0;
  always #5 clk_3x_i = ~clk_3x_i;

  logic                    rst_n, sync_i, in_valid_i;
  logic signed [DW-1:0]    x_re_i, x_im_i;
  logic signed [TW-1:0]    w_re_i, w_im_i;
  logic signed [DW:0]      mul_a_o;
  logic signed [TW:0]      mul_b_o;
  logic signed [DW+TW+1:0] dsp_p_i;
  logic signed [DW-1:0]    z_re_o, z_im_o;
  logic                    out_valid_o, sat_o, locked_o, slip_err_o;

  fft_kar_sched #(.DW(DW), .TW(TW), .MUL_LAT(ML), .LOCK_CNT(LC)) dut (
    .clk_3x_i(clk_3x_i), .rst_n(rst_n), .sync_i(sync_i), .in_valid_i(in_valid_i),
    .x_re_i(x_re_i), .x_im_i(x_im_i), .w_re_i(w_re_i), .w_im_i(w_im_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .dsp_p_i(dsp_p_i),
    .z_re_o(z_re_o), .z_im_o(z_im_o), .out_valid_o(out_valid_o), .sat_o(sat_o),
    .locked_o(locked_o), .slip_err_o(slip_err_o)
  );

  // external multiplier: product of the operands seen ML cycles earlier
  logic signed [DW+TW+1:0] r_mp [0:ML-1];
  always @(posedge clk_3x_i) begin
    r_mp[0] <= mul_a_o * mul_b_o;
    for (int k = 1; k < ML; k++) r_mp[k] <= r_mp[k-1];
  end
  assign dsp_p_i = r_mp[ML-1];

  vec_t tbl [8];
  ev_t  exp_q [$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    ev_t e;
    @(posedge clk_3x_i);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("out_valid", out_valid_o, 1);
      chk("z_re", z_re_o, e.zr);
      chk("z_im", z_im_o, e.zi);
      chk("sat", sat_o, e.sat);
    end else begin
      chk("out_valid_idle", out_valid_o, 0);
    end
  endtask

  task automatic drive(input int i);
    x_re_i     = tbl[i].xr;
    x_im_i     = tbl[i].xi;
    w_re_i     = tbl[i].wr;
    w_im_i     = tbl[i].wi;
    in_valid_i = tbl[i].vld;
  endtask

  task automatic expect_res(input int i);
    ev_t e;
    e.cyc = cyc + 4 + ML;
    e.zr  = tbl[i].ezr;
    e.zi  = tbl[i].ezi;
    e.sat = tbl[i].esat;
    exp_q.push_back(e);
  endtask

  task automatic sync3(input int i);
    drive(i);
    sync_i = 1'b1;
    if (tbl[i].vld) expect_res(i);
    step();
    sync_i = 1'b0;
    step();
    step();
  endtask

  task automatic check_zero(input string tg);
    chk({tg, "_mul_a"}, mul_a_o, 0);
    chk({tg, "_mul_b"}, mul_b_o, 0);
    chk({tg, "_z_re"}, z_re_o, 0);
    chk({tg, "_z_im"}, z_im_o, 0);
    chk({tg, "_out_valid"}, out_valid_o, 0);
    chk({tg, "_sat"}, sat_o, 0);
    chk({tg, "_locked"}, locked_o, 0);
    chk({tg, "_slip"}, slip_err_o, 0);
  endtask

  int sidx [8];

  initial begin
    tbl[0] = '{25'sd1000, -25'sd500, 10'sd511, 10'sd0, 1'b1, 25'sd998, -25'sd500, 1'b0};
    tbl[1] = '{25'sd1000, -25'sd500, 10'sd0, 10'sd511, 1'b1, 25'sd499, 25'sd998, 1'b0};
    tbl[2] = '{MINV, MINV, WMIN, 10'sd0, 1'b1, MAXV, MAXV, 1'b1};
    tbl[3] = '{25'sd3, 25'sd4, 10'sd256, 10'sd0, 1'b1, 25'sd1, 25'sd2, 1'b0};
    tbl[4] = '{-25'sd3, 25'sd0, 10'sd256, 10'sd0, 1'b1, -25'sd2, 25'sd0, 1'b0};
    tbl[5] = '{MAXV, MINV, WMIN, WMIN, 1'b1, MINV, 25'sd1, 1'b1};
    tbl[6] = '{25'sd123, 25'sd456, 10'sd100, -10'sd100, 1'b0, 25'sd0, 25'sd0, 1'b0};
    tbl[7] = '{-25'sd1, -25'sd1, 10'sd1, 10'sd1, 1'b1, 25'sd0, -25'sd1, 1'b0};
    sidx = '{0, 1, 3, 4, 7, 0, 1, 3};

    rst_n = 1'b0; sync_i = 1'b0;
    drive(0);
    step(); step();
    check_zero("rst");

    // unlocked and no sync: operands stay zero despite live inputs
    rst_n = 1'b1;
    step(); step();
    chk("unlock_mul_a", mul_a_o, 0);
    chk("unlock_mul_b", mul_b_o, 0);

    for (int k = 1; k <= 5; k++) begin
      in_valid_i = 1'b0;
      sync_i     = 1'b1;
      step();
      sync_i = 1'b0;
      chk("lock_state", locked_o, (k == 5) ? 1 : 0);
      chk("lock_slip", slip_err_o, 0);
      step(); step();
    end

    for (int i = 0; i < 8; i++) sync3(i);
    sync3(6);
    sync3(6);
    chk("stream_locked", locked_o, 1);
    chk("stream_slip", slip_err_o, 0);

    // early sync in P1: prior sample completes, interrupted one is lost
    sync3(0);
    drive(1);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    step();
    drive(3);
    sync_i = 1'b1;
    expect_res(3);
    step();
    sync_i = 1'b0;
    chk("slip_pulse", slip_err_o, 1);
    chk("slip_unlock", locked_o, 0);
    step();
    chk("slip_one_cycle", slip_err_o, 0);
    step();
    for (int k = 1; k <= 4; k++) begin
      in_valid_i = 1'b0;
      sync_i     = 1'b1;
      step();
      sync_i = 1'b0;
      chk("relock_state", locked_o, (k == 4) ? 1 : 0);
      step(); step();
    end

    // missing sync in P2: slip flagged, free-running slot carries nothing
    drive(7);
    sync_i = 1'b1;
    expect_res(7);
    step();
    sync_i = 1'b0;
    step(); step(); step();
    chk("miss_pulse", slip_err_o, 1);
    chk("miss_unlock", locked_o, 0);
    step();
    chk("miss_one_cycle", slip_err_o, 0);
    step();
    sync3(6);

    // back-to-back stream cut by reset after the fourth sample's result
    for (int k = 0; k < 8; k++) begin
      drive(sidx[k]);
      sync_i = 1'b1;
      if (k < 4) expect_res(sidx[k]);
      step();
      sync_i = 1'b0;
      if (k == 5) rst_n = 1'b0;
      step();
      if (k == 5) check_zero("post_rst");
      step();
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) step();
    chk("all_results_seen", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
